counter5_arbiter: RTL

Two-requester round-robin scheduler that shares one mod-MOD sequence counter. Each granted requester gets a run of LEN full counter cycles (wraps). The block owns the counter state. It clears the counter on grant, advances it while running, counts wraps, and pulses done to the owner on completion. It sits between the control FSMs that need timed mod-5 sequences and the downstream logic that consumes the 4-bit count.

---
 rtl/counter5_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/counter5_arbiter.sv
// Two-requester round-robin scheduler sharing one mod-MOD sequence counter.
// Optional build macro COUNTER5_ARB_PAUSE_EN adds a pause input that freezes RUN.
module counter5_arbiter #(
   parameter int MOD   = 5,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
`ifdef COUNTER5_ARB_PAUSE_EN
   input  logic             pause,
`endif
   input  logic [1:0]       req,
   input  logic [LEN_W-1:0] len0,
   input  logic [LEN_W-1:0] len1,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic [3:0]       cnt_out,
   output logic             wrap,
   output logic [1:0]       done
);

   typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;

   localparam logic [3:0] CNT_MAX = 4'(MOD - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic [1:0]       gnt_q, gnt_d;
   logic [1:0]       done_q, done_d;
   logic             hold;
   logic             owner_req;
   logic             win;

`ifdef COUNTER5_ARB_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   assign owner_req = req[owner_q];
   // A lone request wins outright; a tie goes to whoever was not served last.
   assign win       = (req == 2'b11) ? ~last_q : req[1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      owner_d = owner_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      done_d  = 2'b00;
      wrap    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               state_d = GRANT;
               owner_d = win;
               gnt_d   = win ? 2'b10 : 2'b01;
               rem_d   = win ? len1 : len0;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (!owner_req) begin
               state_d = IDLE;
               gnt_d   = 2'b00;
               cnt_d   = '0;
               rem_d   = '0;
               last_d  = owner_q;
            end else if (rem_q == '0) begin
               state_d = DONE;
               gnt_d   = 2'b00;
               done_d  = gnt_q;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            wrap = !hold && (cnt_q == CNT_MAX);
            if (!owner_req) begin
               state_d = IDLE;
               gnt_d   = 2'b00;
               cnt_d   = '0;
               rem_d   = '0;
               last_d  = owner_q;
            end else if (!hold) begin
               cnt_d = wrap ? 4'd0 : cnt_q + 4'd1;
               if (wrap) begin
                  rem_d = rem_q - 1'b1;
                  if (rem_q == LEN_W'(1)) begin
                     state_d = DONE;
                     gnt_d   = 2'b00;
                     done_d  = gnt_q;
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
            last_d  = owner_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         gnt_q   <= 2'b00;
         done_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
      end
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign cnt_out = cnt_q;
   assign busy    = (state_q == GRANT) || (state_q == RUN);

endmodule
